elevator_car: RTL and testbench
===============================

Name: elevator_car

Overview:
- Behavioural/synthesizable model of the elevator car and its motor: the responder side of the elevator controller's command interface.
- Accepts move commands and door requests from the controller.
- Returns the one-hot floor position, a motion flag, door state and a one-cycle arrival pulse.
- Used in closed loop with the controller in system benches and as the plant model on the FPGA.

Parameters:
- TRAVEL_CYCLES, 4, clock cycles to travel one floor (legal range 1..15).
- DOOR_CYCLES, 3, clock cycles the door stays open per request (legal range 1..15).
- RESET_FLOOR, 3'b001, one-hot floor loaded on reset.

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- move  in  2  command: 00 stop, 01 up, 10 down, 11 reserved (treated as stop).
- door_req  in  1  request to open the door at the current floor.
- floor  out  3  one-hot current/last floor, bit 1 = ground, bit 3 = top.
- moving  out  1  high while travelling between floors.
- door_open  out  1  high while the door is open.
- arrive  out  1  one-cycle pulse on the cycle floor updates after travel.
- fault  out  1  one-cycle pulse on an illegal command (up at top, down at bottom).

Behaviour:
- Reset (asynchronous assert, synchronous release) forces:
  - floor = RESET_FLOOR, moving = 0, door_open = 0, arrive = 0, fault = 0
  - state = IDLE, timer = 0.
  - Reset mid-travel or mid-door abandons the operation; there is no partial-floor state.
- FSM states: IDLE, UP, DOWN, DOOR.
- IDLE, priority order, evaluated at each rising edge:
  - door_req = 1 → DOOR, timer = DOOR_CYCLES-1, door_open = 1 from that edge. door_req beats a simultaneous move command.
  - move = 01 and floor != 3'b100 → UP, timer = TRAVEL_CYCLES-1, moving = 1.
  - move = 10 and floor != 3'b001 → DOWN, timer = TRAVEL_CYCLES-1, moving = 1.
  - move = 01 at top or 10 at bottom → stay IDLE, fault = 1 for one cycle.
  - move = 00 or 11 → stay IDLE.
- UP / DOWN:
  - timer decrements by 1 each edge; inputs are ignored (travel is committed once started).
  - On the edge where timer == 0:
    - floor shifts one position: up = left shift, down = right shift.
    - moving = 0, arrive = 1 for exactly that cycle.
    - Return to IDLE.
  - Latency: command sampled at edge k → moving high from k to k+TRAVEL_CYCLES; floor and arrive change at edge k+TRAVEL_CYCLES.
  - Each command moves exactly one floor. A held move = 01 re-launches from IDLE on the cycle after arrive, so a multi-floor trip costs TRAVEL_CYCLES+1 cycles per floor.
- DOOR:
  - timer decrements each edge; move is ignored.
  - door_req high on the edge where timer == 0 reloads the timer to DOOR_CYCLES-1 and the door stays open.
  - Otherwise, at timer == 0: door_open = 0, return to IDLE.
  - Door open time = DOOR_CYCLES cycles per request.
- Invariants:
  - floor is always exactly one-hot.
  - moving and door_open are never both 1.
  - arrive and fault are never both 1.
  - The floor never leaves the range 3'b001..3'b100.
- Timer is 4 bits and never wraps: it is loaded only on state entry and only decremented when non-zero.

Decomposition:
- Package elevator_pkg:
  - Move codes: MOVE_STOP = 2'b00, MOVE_UP = 2'b01, MOVE_DOWN = 2'b10, MOVE_RSVD = 2'b11.
  - FSM state encoding (IDLE, UP, DOWN, DOOR).
  - Floor constants: FLOOR_1 = 3'b001, FLOOR_2 = 3'b010, FLOOR_3 = 3'b100.
- Sub-module elevator_timer:
  - 4-bit loadable down-counter: inputs load, load_val, en; output zero.
  - Shared by the travel and door phases.
- The FSM and floor shift register live in elevator_car.

Test Plan:
- Reset check: reset pulsed mid-simulation during UP travel → floor = 001 immediately (asynchronous), moving = 0, arrive = 0; after release, IDLE accepts a new command.
- Single up move: from floor 001, move = 01 for 1 cycle at edge k → moving = 1 for edges k..k+3, floor = 010 and arrive = 1 at edge k+4, moving = 0.
- Held up to top: move held at 01 from floor 001 → arrive pulses at edges k+4 and k+9 (floor 010, then 100); next edge fault = 1, floor stays 100.
- Down at bottom and reserved code: floor 001, move = 10 → fault pulse, no motion; move = 11 → no fault, no motion.
- Door priority and extend: floor 010, door_req = 1 and move = 01 on the same edge → door_open = 1 for 3 cycles, no motion; door_req re-asserted on the last door cycle → 3 more open cycles; move during DOOR is ignored.
- Committed travel: during DOWN from 100, toggle move to 01 and assert door_req → ignored; floor = 010 with arrive after 4 cycles, then door_req is honoured.

Source files
------------

// File: rtl/elevator_pkg.sv
// elevator_pkg: shared move codes, FSM state encoding and floor constants for the elevator car
package elevator_pkg;

    localparam logic [1:0] MOVE_STOP = 2'b00;
    localparam logic [1:0] MOVE_UP   = 2'b01;
    localparam logic [1:0] MOVE_DOWN = 2'b10;
    localparam logic [1:0] MOVE_RSVD = 2'b11;

    localparam logic [2:0] FLOOR_1 = 3'b001;
    localparam logic [2:0] FLOOR_2 = 3'b010;
    localparam logic [2:0] FLOOR_3 = 3'b100;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_UP   = 2'b01,
        ST_DOWN = 2'b10,
        ST_DOOR = 2'b11
    } state_e;

endpackage

// File: rtl/elevator_timer.sv
// elevator_timer: 4-bit loadable down-counter that stops at zero, shared by travel and door phases
module elevator_timer (
    input  logic       clk,
    input  logic       reset,
    input  logic       load_i,
    input  logic [3:0] load_val_i,
    input  logic       en_i,
    output logic       zero_o
);

    logic [3:0] cnt_q;
    logic [3:0] cnt_d;

    // load wins over decrement; decrement only while non-zero so the count never wraps
    always_comb begin
        cnt_d = load_i ? load_val_i : (en_i && cnt_q != 4'd0) ? cnt_q - 4'd1 : cnt_q;
    end

    // counter register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) cnt_q <= 4'd0;
        else       cnt_q <= cnt_d;
    end

    assign zero_o = (cnt_q == 4'd0);

endmodule

// File: rtl/elevator_car.sv
// elevator_car: elevator car and motor plant, one floor per move command, timed door with extend
module elevator_car
    import elevator_pkg::*;
#(
    parameter int         TRAVEL_CYCLES = 4,
    parameter int         DOOR_CYCLES   = 3,
    parameter logic [2:0] RESET_FLOOR   = 3'b001
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] move,
    input  logic       door_req,
    output logic [2:0] floor,
    output logic       moving,
    output logic       door_open,
    output logic       arrive,
    output logic       fault
);

    localparam logic [3:0] TRAVEL_LOAD = 4'(TRAVEL_CYCLES - 1);
    localparam logic [3:0] DOOR_LOAD   = 4'(DOOR_CYCLES - 1);

    state_e     state_q, state_d;
    logic [2:0] floor_q, floor_d;
    logic       arrive_q, arrive_d;
    logic       fault_q, fault_d;
    logic       tmr_load;
    logic [3:0] tmr_val;
    logic       tmr_en;
    logic       tmr_zero;

    elevator_timer u_timer (
        .clk        (clk),
        .reset      (reset),
        .load_i     (tmr_load),
        .load_val_i (tmr_val),
        .en_i       (tmr_en),
        .zero_o     (tmr_zero)
    );

    // next state: idle arbitrates door over motion; travel and door phases run their timer to zero
    always_comb begin
        state_d  = state_q;
        floor_d  = floor_q;
        arrive_d = 1'b0;
        fault_d  = 1'b0;
        tmr_load = 1'b0;
        tmr_val  = 4'd0;
        tmr_en   = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (door_req) begin
                    state_d  = ST_DOOR;
                    tmr_load = 1'b1;
                    tmr_val  = DOOR_LOAD;
                end else if (move == MOVE_UP) begin
                    state_d  = (floor_q != FLOOR_3) ? ST_UP : ST_IDLE;
                    tmr_load = (floor_q != FLOOR_3);
                    tmr_val  = TRAVEL_LOAD;
                    fault_d  = (floor_q == FLOOR_3);
                end else if (move == MOVE_DOWN) begin
                    state_d  = (floor_q != FLOOR_1) ? ST_DOWN : ST_IDLE;
                    tmr_load = (floor_q != FLOOR_1);
                    tmr_val  = TRAVEL_LOAD;
                    fault_d  = (floor_q == FLOOR_1);
                end
            end
            ST_UP, ST_DOWN: begin
                tmr_en = 1'b1;
                if (tmr_zero) begin
                    floor_d  = (state_q == ST_UP) ? {floor_q[1:0], 1'b0} : {1'b0, floor_q[2:1]};
                    arrive_d = 1'b1;
                    state_d  = ST_IDLE;
                end
            end
            default: begin
                tmr_en = 1'b1;
                if (tmr_zero) begin
                    state_d  = door_req ? ST_DOOR : ST_IDLE;
                    tmr_load = door_req;
                    tmr_val  = DOOR_LOAD;
                end
            end
        endcase
    end

    // state, floor and pulse registers; reset abandons any travel or door cycle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            floor_q  <= RESET_FLOOR;
            arrive_q <= 1'b0;
            fault_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            floor_q  <= floor_d;
            arrive_q <= arrive_d;
            fault_q  <= fault_d;
        end
    end

    assign floor     = floor_q;
    assign moving    = (state_q == ST_UP) || (state_q == ST_DOWN);
    assign door_open = (state_q == ST_DOOR);
    assign arrive    = arrive_q;
    assign fault     = fault_q;

endmodule

// File: tb/tb_elevator_car.sv
// tb_elevator_car: table vectors, corner sequences and random stimulus against an event-schedule model
module tb_elevator_car;

    localparam int T = 4;
    localparam int D = 3;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [1:0] move = 2'b00;
    logic       door_req = 1'b0;
    logic [2:0] floor;
    logic       moving, door_open, arrive, fault;

    elevator_car #(.TRAVEL_CYCLES(T), .DOOR_CYCLES(D), .RESET_FLOOR(3'b001)) dut (
        .clk       (clk),
        .reset     (reset),
        .move      (move),
        .door_req  (door_req),
        .floor     (floor),
        .moving    (moving),
        .door_open (door_open),
        .arrive    (arrive),
        .fault     (fault)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // reference model: floor as a number 1..3, activity as a kind plus the absolute edge it ends on
    int cyc = 0;
    int m_floor = 1;
    int m_kind = 0;
    int m_end = 0;
    bit m_arr = 0;
    bit m_flt = 0;

    wire [6:0] dut_v = {floor, moving, door_open, arrive, fault};

    function automatic logic [6:0] model_v();
        logic [2:0] oh;
        oh = 3'(1 << (m_floor - 1));
        return {oh, (m_kind == 1 || m_kind == 2), (m_kind == 3), m_arr, m_flt};
    endfunction

    function automatic void model_reset();
        m_floor = 1;
        m_kind = 0;
        m_arr = 0;
        m_flt = 0;
    endfunction

    function automatic void model_edge(input logic [1:0] mv, input logic dr);
        m_arr = 0;
        m_flt = 0;
        if (m_kind == 1 || m_kind == 2) begin
            if (cyc == m_end) begin
                m_floor += (m_kind == 1) ? 1 : -1;
                m_arr = 1;
                m_kind = 0;
            end
        end else if (m_kind == 3) begin
            if (cyc == m_end) begin
                if (dr) m_end = cyc + D;
                else m_kind = 0;
            end
        end else if (dr) begin
            m_kind = 3;
            m_end = cyc + D;
        end else if (mv == 2'b01) begin
            if (m_floor < 3) begin m_kind = 1; m_end = cyc + T; end
            else m_flt = 1;
        end else if (mv == 2'b10) begin
            if (m_floor > 1) begin m_kind = 2; m_end = cyc + T; end
            else m_flt = 1;
        end
    endfunction

    task automatic check(input string name, input logic [6:0] act, input logic [6:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at cycle %0d: got %b expected %b", name, cyc, act, exp);
        end
    endtask

    task automatic apply(input logic [1:0] mv, input logic dr);
        @(negedge clk);
        move = mv;
        door_req = dr;
        @(posedge clk);
        cyc++;
        model_edge(mv, dr);
        #1;
    endtask

    typedef struct {
        logic [1:0] mv;
        logic       dr;
        logic [6:0] exp;
    } vec_t;

    vec_t vecs[21];

    initial begin
        // expected {floor, moving, door_open, arrive, fault} after each edge, from reset at floor 1
        vecs[0]  = '{2'b01, 1'b0, 7'b001_1_0_0_0};
        vecs[1]  = '{2'b00, 1'b0, 7'b001_1_0_0_0};
        vecs[2]  = '{2'b10, 1'b0, 7'b001_1_0_0_0};
        vecs[3]  = '{2'b00, 1'b0, 7'b001_1_0_0_0};
        vecs[4]  = '{2'b00, 1'b0, 7'b010_0_0_1_0};
        vecs[5]  = '{2'b11, 1'b0, 7'b010_0_0_0_0};
        vecs[6]  = '{2'b01, 1'b1, 7'b010_0_1_0_0};
        vecs[7]  = '{2'b01, 1'b0, 7'b010_0_1_0_0};
        vecs[8]  = '{2'b00, 1'b0, 7'b010_0_1_0_0};
        vecs[9]  = '{2'b00, 1'b1, 7'b010_0_1_0_0};
        vecs[10] = '{2'b10, 1'b0, 7'b010_0_1_0_0};
        vecs[11] = '{2'b00, 1'b0, 7'b010_0_1_0_0};
        vecs[12] = '{2'b00, 1'b0, 7'b010_0_0_0_0};
        vecs[13] = '{2'b10, 1'b0, 7'b010_1_0_0_0};
        vecs[14] = '{2'b00, 1'b0, 7'b010_1_0_0_0};
        vecs[15] = '{2'b01, 1'b1, 7'b010_1_0_0_0};
        vecs[16] = '{2'b00, 1'b0, 7'b010_1_0_0_0};
        vecs[17] = '{2'b00, 1'b0, 7'b001_0_0_1_0};
        vecs[18] = '{2'b10, 1'b0, 7'b001_0_0_0_1};
        vecs[19] = '{2'b00, 1'b0, 7'b001_0_0_0_0};
        vecs[20] = '{2'b11, 1'b0, 7'b001_0_0_0_0};

        repeat (3) @(posedge clk);
        #1;
        check("reset_state", dut_v, 7'b001_0_0_0_0);
        @(negedge clk);
        reset = 1'b0;

        foreach (vecs[i]) begin
            apply(vecs[i].mv, vecs[i].dr);
            check($sformatf("vec%0d", i), dut_v, vecs[i].exp);
            check($sformatf("vec%0d_model", i), dut_v, model_v());
        end

        // held up from floor 1 to the top, then one more up faults
        for (int i = 0; i < 11; i++) begin
            apply(2'b01, 1'b0);
            check("held_up", dut_v, model_v());
            if (i == 4) check("held_arr1", {1'b0, floor, arrive, 2'b00}, 7'b0_010_1_00);
            if (i == 9) check("held_arr2", {1'b0, floor, arrive, 2'b00}, 7'b0_100_1_00);
            if (i == 10) check("held_fault", {1'b0, floor, fault, 2'b00}, 7'b0_100_1_00);
        end
        apply(2'b00, 1'b0);
        check("top_idle", dut_v, 7'b100_0_0_0_0);

        // down from the top is committed: later move/door inputs are ignored until arrival
        apply(2'b10, 1'b0);
        check("commit_start", dut_v, 7'b100_1_0_0_0);
        for (int i = 1; i < 4; i++) begin
            apply(2'b01, 1'b1);
            check("commit_travel", dut_v, 7'b100_1_0_0_0);
        end
        apply(2'b01, 1'b1);
        check("commit_arrive", dut_v, 7'b010_0_0_1_0);
        apply(2'b00, 1'b1);
        check("commit_door", dut_v, 7'b010_0_1_0_0);
        for (int i = 0; i < 3; i++) begin
            apply(2'b00, 1'b0);
            check("commit_close", dut_v, model_v());
        end
        check("commit_closed", dut_v, 7'b010_0_0_0_0);

        // asynchronous reset in the middle of an up trip from floor 2
        apply(2'b01, 1'b0);
        apply(2'b00, 1'b0);
        check("pre_reset", dut_v, 7'b010_1_0_0_0);
        #2 reset = 1'b1;
        #1;
        check("async_reset", dut_v, 7'b001_0_0_0_0);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        apply(2'b01, 1'b0);
        check("post_reset_move", dut_v, 7'b001_1_0_0_0);
        check("post_reset_model", dut_v, model_v());

        // random stimulus against the model
        for (int i = 0; i < 400; i++) begin
            apply(2'($urandom_range(0, 3)), ($urandom_range(0, 3) == 0));
            check("random", dut_v, model_v());
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
